// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver. Synchronises and de-glitches the
//            PS/2 clock/data lines, deframes 11-bit frames, validates start,
//            parity and stop bits, optionally folds E0/F0 prefixes into
//            flagged key words, and queues the results in a FWFT FIFO.
//            Receive only: the PS/2 lines are never driven.
// Revision : 1.0  initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 8,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000,
    parameter int RAW_MODE    = 0
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic                       PS2_CLK,
    input  logic                       PS2_DAT,
    input  logic                       rd_en,
    input  logic                       clr_ovf,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    output logic                       frame_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int FW  = $clog2(FILTER_LEN + 1);
    localparam int WW  = $clog2(TIMEOUT_CYC + 1);
    localparam bit RAW = (RAW_MODE != 0);

    // ------------------------------------------------------------------
    // Input conditioning: index 0 = PS/2 clock, index 1 = PS/2 data
    // ------------------------------------------------------------------
    logic [1:0] line_in;
    logic [1:0] filt;

    assign line_in = {PS2_DAT, PS2_CLK};

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic          sync_a;
        logic          sync_b;
        logic          level;
        logic [FW-1:0] cnt;

        // Two-flop synchroniser, then accept a new level only after it has
        // been seen on FILTER_LEN consecutive cycles.
        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
                sync_a <= 1'b1;
                sync_b <= 1'b1;
                level  <= 1'b1;
                cnt    <= '0;
            end else begin
                sync_a <= line_in[i];
                sync_b <= sync_a;
                if (sync_b != level) begin
                    if (cnt == FW'(FILTER_LEN - 1)) begin
                        level <= sync_b;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + FW'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign filt[i] = level;
    end

    logic clk_prev;
    logic fall_tick;
    logic filt_dat;

    assign filt_dat  = filt[1];
    assign fall_tick = clk_prev & ~filt[0];

    // Previous filtered clock level for falling-edge detection
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) clk_prev <= 1'b1;
        else       clk_prev <= filt[0];
    end

    // ------------------------------------------------------------------
    // Deframer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [3:0]    bitcnt;
    logic [9:0]    shreg;     // [7:0] data, [8] parity, [9] stop
    logic [WW-1:0] wd;
    logic          start_frm;
    logic          shift_en;
    logic          good_frm;
    logic          clear_flags;
    logic          err_evt;
    logic          timeout;
    logic          frame_ok;

    // Odd parity over data+parity, and a high stop bit
    assign frame_ok = (^shreg[8:0]) & shreg[9];

    // Deframer state register
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_n;
    end

    // Deframer next-state and control strobes
    always_comb begin
        state_n     = state;
        start_frm   = 1'b0;
        shift_en    = 1'b0;
        good_frm    = 1'b0;
        clear_flags = 1'b0;
        err_evt     = 1'b0;
        timeout     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fall_tick) begin
                    if (!filt_dat) begin
                        start_frm = 1'b1;
                        state_n   = S_RECV;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (fall_tick) begin
                    shift_en = 1'b1;
                    if (bitcnt == 4'd10) state_n = S_CHECK;
                end else if (wd == WW'(TIMEOUT_CYC)) begin
                    timeout     = 1'b1;
                    err_evt     = 1'b1;
                    clear_flags = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            S_CHECK: begin
                if (frame_ok) begin
                    good_frm = 1'b1;
                end else begin
                    err_evt     = 1'b1;
                    clear_flags = 1'b1;
                end
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    logic       dec_valid;
    logic [7:0] dec_byte;

    // Bit counter, shift register, watchdog and hand-off to the decoder
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            bitcnt    <= '0;
            shreg     <= '0;
            wd        <= '0;
            dec_valid <= 1'b0;
            dec_byte  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (start_frm)              bitcnt <= 4'd1;
            else if (shift_en)          bitcnt <= bitcnt + 4'd1;
            else if (state != S_RECV)   bitcnt <= '0;

            if (shift_en) shreg <= {filt_dat, shreg[9:1]};

            if (state == S_RECV && !fall_tick && !timeout) wd <= wd + WW'(1);
            else                                           wd <= '0;

            dec_valid <= good_frm;
            if (good_frm) dec_byte <= shreg[7:0];
            frame_err <= err_evt;
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    logic              ext;
    logic              brk;
    logic              is_e0;
    logic              is_f0;
    logic              push;
    logic [DATA_W-1:0] push_word;

    assign is_e0 = (dec_byte == 8'hE0);
    assign is_f0 = (dec_byte == 8'hF0);

    // Word to enqueue and whether this decoded byte produces one
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        push_word[7:0] = dec_byte;
        if (RAW) begin
            push = dec_valid;
        end else begin
            push         = dec_valid & ~is_e0 & ~is_f0;
            push_word[8] = ext;
            push_word[9] = brk;
        end
    end

    // Extended/break prefix flags; a bad frame or timeout forgets them
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (clear_flags) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (dec_valid && !RAW) begin
            if (is_e0) begin
                ext <= 1'b1;
            end else if (is_f0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              wr;
    logic              rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd    = rd_en & ~empty;
    // A push at full still fits when the head is popped on the same edge
    assign wr    = push & (~full | rd);

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge CLOCK_50) begin
        if (wr) mem[wptr] <= push_word;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            unique case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !rd) overflow <= 1'b1;
            else if (clr_ovf)        overflow <= 1'b0;
        end
    end

    assign data_valid = ~empty;
    assign fifo_count = count;
    assign data_out   = empty ? '0 : mem[rptr];

endmodule
`default_nettype wire
